regfile_mp: RTL

Parametrised multi-port integer register file with an in-built busy-bit scoreboard. It is the next-generation replacement for the single-write, two-read NPC register file. It provides NRD combinational read ports, NWR synchronous write ports, and a per-register pending-write tracker. The decode stage uses the tracker for RAW/WAW interlock, and writeback clears it. It sits between decode/issue (reads, issue) and writeback (writes).

---
 rtl/regfile_mp.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register pending-write scoreboard.
// Latency: reads are combinational; writes, busy bits and O_busy_cnt update on the rising clk edge.
// Backpressure: O_iss_ready drops on a WAW hazard; the issuer must hold I_iss_valid/I_iss_addr until it is accepted.
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports and mask O_rs_busy for a register being written back in that cycle.
//
// Ports (port k of a flattened vector occupies slice [k*W +: W]):
//   clk, rst             clock, asynchronous active-high reset
//   I_rs_raddr/O_rs_*    NRD read ports: address, data, pending-write flag
//   I_rd_we/waddr/wdata  NWR write ports; the highest index wins a same-address conflict
//   I_iss_valid/addr     issue request marking a destination register pending
//   O_iss_ready          issue accepted (destination not pending, or being cleared now)
//   O_busy_cnt           number of registers currently pending
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    I_rs_raddr,
  output logic [NRD*XLEN-1:0]  O_rs_rdata,
  output logic [NRD-1:0]       O_rs_busy,
  input  logic [NWR-1:0]       I_rd_we,
  input  logic [NWR*AW-1:0]    I_rd_waddr,
  input  logic [NWR*XLEN-1:0]  I_rd_wdata,
  input  logic                 I_iss_valid,
  input  logic [AW-1:0]        I_iss_addr,
  output logic                 O_iss_ready,
  output logic [AW:0]          O_busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  // Bit 0 exists only to keep indexing uniform; nothing ever sets it.
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;

  // Registers being written back this cycle (x0 excluded).
  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NWR; k++) begin
      if (I_rd_we[k] && (I_rd_waddr[k*AW +: AW] != '0)) begin
        clr_vec[I_rd_waddr[k*AW +: AW]] = 1'b1;
      end
    end
  end

  // A writeback to the destination in the same cycle resolves the WAW hazard.
  assign O_iss_ready = ~busy[I_iss_addr] | clr_vec[I_iss_addr] | (I_iss_addr == '0);

  always_comb begin
    set_vec = '0;
    if (I_iss_valid && O_iss_ready && (I_iss_addr != '0)) begin
      set_vec[I_iss_addr] = 1'b1;
    end
  end

  // Set after clear: a new producer issued alongside the old one's writeback stays pending.
  assign busy_nxt = (busy & ~clr_vec) | set_vec;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      O_busy_cnt <= '0;
    end else begin
      busy       <= busy_nxt;
      O_busy_cnt <= cnt_nxt;
    end
  end

  // Ascending port order: the last (highest-index) assignment to an address takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (I_rd_we[k] && (I_rd_waddr[k*AW +: AW] != '0)) begin
          regs[I_rd_waddr[k*AW +: AW]] <= I_rd_wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // regs[0] is never written, so x0 reads zero and busy[0] is never set.
  always_comb begin
    O_rs_rdata = '0;
    O_rs_busy  = '0;
    for (int r = 0; r < NRD; r++) begin
      O_rs_rdata[r*XLEN +: XLEN] = regs[I_rs_raddr[r*AW +: AW]];
      O_rs_busy[r]               = busy[I_rs_raddr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWR; k++) begin
        if (I_rd_we[k] && (I_rd_waddr[k*AW +: AW] != '0) &&
            (I_rd_waddr[k*AW +: AW] == I_rs_raddr[r*AW +: AW])) begin
          O_rs_rdata[r*XLEN +: XLEN] = I_rd_wdata[k*XLEN +: XLEN];
          O_rs_busy[r]               = 1'b0;
        end
      end
`endif
    end
  end

endmodule
